sccb_arbiter: RTL and testbench
===============================

# sccb_arbiter

Shares the single SCCB write driver between up to four requesters, e.g. the power-up register configuration sequencer on port 0 and runtime requesters such as exposure, flash or test-pattern control. It sequences one complete register write at a time onto the driver's trig/addr/data/end handshake and returns per-port accept and completion pulses. An optional watchdog aborts hung transactions.

## Interface
Parameters:
- NUM_REQ, 2: number of requester ports, legal range 2..4.
- GAP_CYCLES, 2: idle clocks inserted between consecutive driver transactions, legal range 1..15.
- TIMEOUT_CYCLES, 1023: WAIT-state clocks before abort, legal range 16..4095. Used only with the watchdog compiled in.

Ports:
- clk  in  1  system clock. One clock only.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  NUM_REQ  per-port level request. Held until that port's ack.
- req_addr  in  16*NUM_REQ  register address. Port i occupies bits [16i+15:16i].
- req_data  in  8*NUM_REQ  register data. Port i occupies bits [8i+7:8i].
- prio_lock  in  1  when high, only port 0 is eligible. Tied to "init not finished".
- ack  out  NUM_REQ  one-cycle pulse: request latched.
- done  out  NUM_REQ  one-cycle pulse: that port's transaction finished.
- trig  out  1  one-cycle start pulse to the driver.
- driver_addr  out  16  registered address to the driver.
- driver_data  out  8  registered data to the driver.
- driver_end  in  1  one-cycle completion pulse from the driver.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  one-cycle abort pulse. Constant 0 when the watchdog is compiled out.

## Operation
- FSM states: IDLE, ISSUE, WAIT, GAP.
- IDLE:
  - The eligible set is req, masked to port 0 when prio_lock=1.
  - If the set is non-empty, pick round-robin starting at last_owner+1, wrapping modulo NUM_REQ.
  - Latch the winner's addr/data into driver_addr/driver_data, set owner and last_owner to the winner, pulse ack[owner], then go to ISSUE.
- ISSUE: assert trig for exactly one cycle, then go to WAIT.
- WAIT:
  - On driver_end=1: pulse done[owner], load the gap counter, go to GAP.
  - With the watchdog compiled in, the timeout path below also applies.
- GAP: count GAP_CYCLES clocks, then go to IDLE. Requests are not evaluated in GAP.
- driver_end is ignored in IDLE, ISSUE and GAP. It has no effect on state or outputs there.
- A request deasserted before ack is simply dropped. Nothing is latched.
- prio_lock changing mid-transaction does not affect the current owner. It applies only at the next IDLE pick.
- req_addr/req_data are sampled only in the IDLE grant cycle. driver_addr/driver_data hold their values until the next grant.

## Timing
- Reset values: state=IDLE, ack=0, done=0, trig=0, driver_addr=0, driver_data=0, busy=0, timeout_err=0, last_owner=NUM_REQ-1 (so port 0 is favoured first), all counters 0.
- If req is seen by IDLE at edge n:
  - ack and driver_addr/driver_data are valid in cycle n+1.
  - trig is high in cycle n+2.
- driver_end at edge m gives done in cycle m+1. The next grant is possible at edge m+GAP_CYCLES+1 at the earliest.
- A requester must drop req by the cycle after ack, or it is granted again after the gap.
- Reset asserted mid-operation returns the block to IDLE immediately. No done pulse is produced for the aborted transaction.
- Simultaneous requests are resolved in one cycle. There are no bubbles between candidates.

## Configuration
- Macro SCCB_ARB_TIMEOUT_EN.
- Defined:
  - A 12-bit WAIT counter runs from 0.
  - When it reaches TIMEOUT_CYCLES with no driver_end, pulse timeout_err and done[owner] in the same cycle, then go to GAP.
  - driver_end arriving on that same edge takes precedence: normal done, no timeout_err.
- Undefined: no counter. WAIT waits indefinitely. timeout_err is tied to 0.

## Structure
- Package sccb_pkg holds:
  - the state enum (IDLE/ISSUE/WAIT/GAP);
  - SCCB_ADDR_W=16 and SCCB_DATA_W=8;
  - the MAX_REQ=4 constant.
- Sub-module rr_pick: combinational round-robin selector. Inputs are the eligible mask and last_owner. Outputs are a valid flag and the winner index.
- The FSM, latches and counters live in sccb_arbiter.

## Test plan
- Single port 1 write, addr 0x3008, data 0x82, driver model end after 40 cycles → ack[1] one cycle, trig one cycle later with driver_addr=0x3008 and driver_data=0x82, done[1] one cycle after driver_end, busy low after 2 gap cycles.
- Ports 0 and 1 request together from reset → port 0 granted first, port 1 granted after GAP. Repeated simultaneous requests alternate 0,1,0,1.
- prio_lock=1 with port 1 requesting continuously and port 0 issuing 3 writes → only port 0 is acked. Port 1 is acked in the first IDLE after prio_lock falls.
- Spurious driver_end in IDLE and in ISSUE → no done, no state change. Transaction completes normally on the real end.
- Watchdog compiled in, TIMEOUT_CYCLES=16, driver never ends → timeout_err and done[owner] on the 16th WAIT cycle, then the next grant after the gap. Compiled out → busy stays high.
- rst_n pulled low during WAIT → all outputs return to reset values asynchronously. After release, the first grant goes to port 0.

Source files
------------

// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB write-driver arbiter.
package sccb_pkg;

    localparam int unsigned SCCB_ADDR_W = 16;
    localparam int unsigned SCCB_DATA_W = 8;
    localparam int unsigned MAX_REQ     = 4;
    localparam int unsigned IDX_W       = $clog2(MAX_REQ);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_GAP
    } sccb_state_e;

endpackage

// File: rtl/sccb_arbiter_rr_pick.sv
// Combinational round-robin selector: first set bit of mask_i searching
// upward from last_i+1, wrapping modulo NUM_REQ.
module rr_pick
    import sccb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] mask_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   winner_o
);

    always_comb begin
        valid_o  = 1'b0;
        winner_o = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!valid_o && mask_i[i] && (i == (32'(last_i) + k) % NUM_REQ)) begin
                    valid_o  = 1'b1;
                    winner_o = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/sccb_arbiter.sv
// Arbitrates up to four requesters onto one SCCB write driver, one register
// write at a time. Optional WAIT watchdog enabled by SCCB_ARB_TIMEOUT_EN.
module sccb_arbiter
    import sccb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [16*NUM_REQ-1:0]    req_addr,
    input  logic [8*NUM_REQ-1:0]     req_data,
    input  logic                     prio_lock,
    output logic [NUM_REQ-1:0]       ack,
    output logic [NUM_REQ-1:0]       done,
    output logic                     trig,
    output logic [SCCB_ADDR_W-1:0]   driver_addr,
    output logic [SCCB_DATA_W-1:0]   driver_data,
    input  logic                     driver_end,
    output logic                     busy,
    output logic                     timeout_err
);

    sccb_state_e              state_q;
    logic [NUM_REQ-1:0]       ack_q;
    logic [NUM_REQ-1:0]       done_q;
    logic                     trig_q;
    logic [SCCB_ADDR_W-1:0]   addr_q;
    logic [SCCB_DATA_W-1:0]   data_q;
    logic [IDX_W-1:0]         owner_q;
    logic [IDX_W-1:0]         last_q;
    logic [3:0]               gap_q;

    logic [NUM_REQ-1:0]       elig;
    logic                     pick_valid;
    logic [IDX_W-1:0]         pick_idx;
    logic [SCCB_ADDR_W-1:0]   sel_addr;
    logic [SCCB_DATA_W-1:0]   sel_data;

    always_comb begin
        elig = req;
        if (prio_lock) begin
            elig[NUM_REQ-1:1] = '0;
        end
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == pick_idx) begin
                sel_addr = req_addr[i*SCCB_ADDR_W +: SCCB_ADDR_W];
                sel_data = req_data[i*SCCB_DATA_W +: SCCB_DATA_W];
            end
        end
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .mask_i   (elig),
        .last_i   (last_q),
        .valid_o  (pick_valid),
        .winner_o (pick_idx)
    );

`ifdef SCCB_ARB_TIMEOUT_EN
    logic [11:0] wcnt_q;
    logic        tmo_q;
    logic [11:0] wcnt_inc;

    assign wcnt_inc    = wcnt_q + 12'd1;
    assign timeout_err = tmo_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ack_q   <= '0;
            done_q  <= '0;
            trig_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            owner_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            gap_q   <= '0;
`ifdef SCCB_ARB_TIMEOUT_EN
            wcnt_q  <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            ack_q  <= '0;
            done_q <= '0;
            trig_q <= 1'b0;
`ifdef SCCB_ARB_TIMEOUT_EN
            tmo_q  <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        addr_q  <= sel_addr;
                        data_q  <= sel_data;
                        owner_q <= pick_idx;
                        last_q  <= pick_idx;
                        for (int unsigned i = 0; i < NUM_REQ; i++) begin
                            ack_q[i] <= (IDX_W'(i) == pick_idx);
                        end
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    trig_q  <= 1'b1;
`ifdef SCCB_ARB_TIMEOUT_EN
                    wcnt_q  <= '0;
`endif
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A real end on the expiry edge wins over the watchdog.
                    if (driver_end) begin
                        for (int unsigned i = 0; i < NUM_REQ; i++) begin
                            done_q[i] <= (IDX_W'(i) == owner_q);
                        end
                        gap_q   <= 4'(GAP_CYCLES - 1);
                        state_q <= ST_GAP;
                    end
`ifdef SCCB_ARB_TIMEOUT_EN
                    else if (wcnt_inc == 12'(TIMEOUT_CYCLES)) begin
                        for (int unsigned i = 0; i < NUM_REQ; i++) begin
                            done_q[i] <= (IDX_W'(i) == owner_q);
                        end
                        tmo_q   <= 1'b1;
                        gap_q   <= 4'(GAP_CYCLES - 1);
                        state_q <= ST_GAP;
                    end else begin
                        wcnt_q <= wcnt_inc;
                    end
`endif
                end
                ST_GAP: begin
                    if (gap_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q - 4'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifndef SCCB_ARB_TIMEOUT_EN
    // Always 0 for any legal TIMEOUT_CYCLES; keeps the parameter referenced.
    assign timeout_err = (TIMEOUT_CYCLES == 0);
`endif

    assign ack         = ack_q;
    assign done        = done_q;
    assign trig        = trig_q;
    assign driver_addr = addr_q;
    assign driver_data = data_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sccb_arbiter.sv
// Directed self-checking bench for sccb_arbiter (2 ports, gap 2, timeout 16).
module tb_sccb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [31:0] req_addr;
    logic [15:0] req_data;
    logic        prio_lock;
    logic [1:0]  ack;
    logic [1:0]  done;
    logic        trig;
    logic [15:0] driver_addr;
    logic [7:0]  driver_data;
    logic        driver_end;
    logic        busy;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    sccb_arbiter #(
        .NUM_REQ        (2),
        .GAP_CYCLES     (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .prio_lock   (prio_lock),
        .ack         (ack),
        .done        (done),
        .trig        (trig),
        .driver_addr (driver_addr),
        .driver_data (driver_data),
        .driver_end  (driver_end),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack();
        for (int k = 0; k < 20; k++) begin
            if (ack != 2'b00) break;
            step();
        end
    endtask

    task automatic run_txn(input string tag, input logic [1:0] exp_ack,
                           input logic [15:0] exp_addr, input logic [7:0] exp_data);
        wait_ack();
        chk({tag, "_ack"}, 32'(ack), 32'(exp_ack));
        chk({tag, "_addr"}, 32'(driver_addr), 32'(exp_addr));
        chk({tag, "_data"}, 32'(driver_data), 32'(exp_data));
        step();
        chk({tag, "_trig"}, 32'(trig), 32'd1);
        step();
        driver_end = 1'b1;
        step();
        driver_end = 1'b0;
        chk({tag, "_done"}, 32'(done), 32'(exp_ack));
    endtask

    initial begin
        rst_n      = 1'b0;
        req        = 2'b00;
        req_addr   = '0;
        req_data   = '0;
        prio_lock  = 1'b0;
        driver_end = 1'b0;
        repeat (3) step();

        // reset values
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_trig", 32'(trig), 32'd0);
        chk("rst_addr", 32'(driver_addr), 32'd0);
        chk("rst_data", 32'(driver_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tmo", 32'(timeout_err), 32'd0);
        rst_n = 1'b1;
        step();

        // single port-1 write
        req = 2'b10;
        req_addr[31:16] = 16'h3008;
        req_data[15:8]  = 8'h82;
        step();
        chk("t1_ack", 32'(ack), 32'h2);
        chk("t1_addr", 32'(driver_addr), 32'h3008);
        chk("t1_data", 32'(driver_data), 32'h82);
        chk("t1_trig0", 32'(trig), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        req = 2'b00;
        step();
        chk("t1_trig", 32'(trig), 32'd1);
        chk("t1_ack_off", 32'(ack), 32'd0);
        step();
        chk("t1_trig_off", 32'(trig), 32'd0);
        repeat (37) step();
        chk("t1_nodone", 32'(done), 32'd0);
        chk("t1_wait_busy", 32'(busy), 32'd1);
        driver_end = 1'b1;
        step();
        driver_end = 1'b0;
        chk("t1_done", 32'(done), 32'h2);
        chk("t1_hold_addr", 32'(driver_addr), 32'h3008);
        step();
        chk("t1_done_off", 32'(done), 32'd0);
        chk("t1_gap_busy", 32'(busy), 32'd1);
        step();
        chk("t1_idle", 32'(busy), 32'd0);

        // simultaneous requests from reset, round-robin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        req_addr = {16'h2222, 16'h1111};
        req_data = {8'h22, 8'h11};
        req = 2'b11;
        run_txn("rr0a", 2'b01, 16'h1111, 8'h11);
        step();
        chk("rr_gap1", 32'(ack), 32'd0);
        step();
        chk("rr_gap2", 32'(ack), 32'd0);
        chk("rr_gap2_busy", 32'(busy), 32'd0);
        step();
        chk("rr_regrant", 32'(ack), 32'h2);
        run_txn("rr1a", 2'b10, 16'h2222, 8'h22);
        run_txn("rr0b", 2'b01, 16'h1111, 8'h11);
        run_txn("rr1b", 2'b10, 16'h2222, 8'h22);

        // prio_lock: only port 0 while locked
        prio_lock = 1'b1;
        run_txn("lk0", 2'b01, 16'h1111, 8'h11);
        run_txn("lk1", 2'b01, 16'h1111, 8'h11);
        run_txn("lk2", 2'b01, 16'h1111, 8'h11);
        prio_lock = 1'b0;
        req = 2'b10;
        run_txn("unlk", 2'b10, 16'h2222, 8'h22);
        req = 2'b00;

        // spurious driver_end in IDLE and ISSUE
        repeat (3) step();
        chk("sp_idle_busy", 32'(busy), 32'd0);
        driver_end = 1'b1;
        step();
        driver_end = 1'b0;
        chk("sp_idle_done", 32'(done), 32'd0);
        chk("sp_idle_state", 32'(busy), 32'd0);
        req_addr[15:0] = 16'h1234;
        req_data[7:0]  = 8'h56;
        req = 2'b01;
        step();
        chk("sp_ack", 32'(ack), 32'h1);
        req = 2'b00;
        driver_end = 1'b1;
        step();
        driver_end = 1'b0;
        chk("sp_issue_trig", 32'(trig), 32'd1);
        chk("sp_issue_done", 32'(done), 32'd0);
        step();
        chk("sp_wait_busy", 32'(busy), 32'd1);
        chk("sp_wait_done", 32'(done), 32'd0);
        repeat (5) step();
        driver_end = 1'b1;
        step();
        driver_end = 1'b0;
        chk("sp_done", 32'(done), 32'h1);
        chk("sp_addr", 32'(driver_addr), 32'h1234);
        repeat (2) step();

`ifdef SCCB_ARB_TIMEOUT_EN
        // watchdog: no driver_end
        req = 2'b10;
        step();
        chk("wd_ack", 32'(ack), 32'h2);
        req = 2'b00;
        step();
        chk("wd_trig", 32'(trig), 32'd1);
        repeat (15) step();
        chk("wd_pre_tmo", 32'(timeout_err), 32'd0);
        chk("wd_pre_done", 32'(done), 32'd0);
        step();
        chk("wd_tmo", 32'(timeout_err), 32'd1);
        chk("wd_done", 32'(done), 32'h2);
        req = 2'b01;
        step();
        step();
        chk("wd_gap_ack", 32'(ack), 32'd0);
        chk("wd_tmo_off", 32'(timeout_err), 32'd0);
        step();
        chk("wd_next_ack", 32'(ack), 32'h1);
        req = 2'b00;
        step();
        step();
        driver_end = 1'b1;
        step();
        driver_end = 1'b0;
        chk("wd_next_done", 32'(done), 32'h1);
        repeat (2) step();
`else
        // no watchdog: WAIT holds indefinitely
        req = 2'b10;
        step();
        chk("nw_ack", 32'(ack), 32'h2);
        req = 2'b00;
        step();
        chk("nw_trig", 32'(trig), 32'd1);
        repeat (40) step();
        chk("nw_busy", 32'(busy), 32'd1);
        chk("nw_tmo", 32'(timeout_err), 32'd0);
        chk("nw_nodone", 32'(done), 32'd0);
        driver_end = 1'b1;
        step();
        driver_end = 1'b0;
        chk("nw_done", 32'(done), 32'h2);
        repeat (2) step();
`endif

        // async reset during WAIT
        req = 2'b10;
        step();
        chk("ar_ack", 32'(ack), 32'h2);
        req = 2'b00;
        step();
        repeat (3) step();
        chk("ar_wait_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_addr", 32'(driver_addr), 32'd0);
        chk("ar_data", 32'(driver_data), 32'd0);
        chk("ar_trig", 32'(trig), 32'd0);
        chk("ar_ack0", 32'(ack), 32'd0);
        driver_end = 1'b1;
        step();
        driver_end = 1'b0;
        chk("ar_nodone", 32'(done), 32'd0);
        rst_n = 1'b1;
        req = 2'b11;
        step();
        chk("ar_first_grant", 32'(ack), 32'h1);
        req = 2'b00;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
